uart_loader_ctrl: RTL
=====================

# uart_loader_ctrl

Framed UART boot-loader and TX arbiter between the UART pair and `core`. Parses a byte-command protocol from `uart_rx` and issues word writes on the core's instruction or data load port. Sequences `run` with a start delay. Shares the single `uart_tx` between loader acknowledgements and the core output FIFO. Replaces switch-driven loading in the board top.

## Interface
Parameters:
- `RUN_DELAY`, 100: cycles from accepted `R` command to `run` rising.
- `TIMEOUT`, 5000000: idle cycles mid-packet before abort (100 ms at 50 MHz).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `rx_rd` in 1: `uart_rx` byte-ready level.
  - A byte is accepted on its rising edge, detected internally against a registered copy.
- `rx_dout` in 8: received byte; valid while `rx_rd` is high.
- `insn_addr` out 32, `insn_din` out 32, `insn_we` out 1: instruction load port.
- `data_addr` out 32, `data_din` out 32, `data_we` out 1: data load port.
- `run` out 1: core run enable.
- `fifo_valid` in 1: core output FIFO (first-word-fall-through) has data.
- `fifo_dout` in 32: FIFO head word.
- `fifo_rd_en` out 1: FIFO pop.
- `tx_ready` in 1: `uart_tx` idle.
- `tx_wr` out 1: send kick to `uart_tx`.
- `tx_din` out 32: word to `uart_tx`.
- `ack_drop` out 1: one-cycle pulse when an ack is discarded.

## Operation
Packet format. All multi-byte fields are little-endian.
- `0x49` ('I') / `0x44` ('D'): 4 address bytes, 2 count bytes N, then 4·N payload bytes.
  - Each 4 bytes form one word: first byte goes to [7:0].
- `0x52` ('R'): start.
- `0x48` ('H'): halt.

State machine, with a 2-bit byte index `idx`:
- IDLE:
  - 'I'/'D' → latch target, force `run`=0, go to ADDR.
  - 'R' → arm the run-delay counter; queue ack; stay in IDLE.
  - 'H' → `run`=0, cancel a pending delay, queue ack.
  - Any other byte → error ack `{8'h45, byte, 16'h0000}`.
- ADDR: 4 bytes, then LEN.
- LEN: 2 bytes.
  - N=0 → ack, then IDLE.
  - N>0 → PAYLOAD.
- PAYLOAD: shift bytes into a word buffer. On the 4th byte:
  - Write the word to the target at `base + 4·k`, k = 0..N-1.
  - Address arithmetic is 32-bit and wraps modulo 2^32.
  - After word N-1 → ack, then IDLE.
- Success ack: `{8'h4B, cmd, N[15:0]}`; N=0 for 'R' and 'H'.

Run sequencing:
- The delay counter loads `RUN_DELAY` and decrements each cycle.
- `run` rises on the cycle after the counter reaches 0.
- 'R' while `run`=1: ack only, no change.

Ack slot:
- One entry deep.
- A new ack while the slot is full is discarded, and `ack_drop` pulses.

TX arbiter:
- Issues a kick when `tx_ready`=1, `tx_wr` was 0 the previous cycle, and a source is pending.
- The ack slot has priority over the FIFO.
- When the FIFO is the source, `fifo_rd_en` pulses in the same cycle as `tx_wr`, and `tx_din` = `fifo_dout`.
- When the ack slot is the source, `tx_din` = ack word and the slot clears.

## Timing
- Reset values:
  - All write enables, `run`, `tx_wr`, `fifo_rd_en` and `ack_drop` are 0.
  - Addresses, data and `tx_din` are 0.
  - State is IDLE; the ack slot is empty; the delay counter is idle.
- Byte acceptance: the cycle in which `rx_rd`=1 and the registered `rx_rd`=0.
- Write latency: `*_we` asserts 1 cycle after acceptance of the word's 4th byte, for exactly 1 cycle. `*_addr`/`*_din` are valid in the same cycle and held afterwards.
- The ack enters the slot in the same cycle as the final write. The earliest `tx_wr` is the following cycle.
- `tx_wr` and `fifo_rd_en` are never high on two consecutive cycles.
- Simultaneous events:
  - If a FIFO word and an ack are both pending, the ack is sent first.
  - If the delay counter expires in the same cycle an 'I'/'D' header is accepted, the header wins and `run` stays 0.
- Reset asserted mid-packet: the partial packet is discarded, and no write or ack is issued.

## Configuration
- `UART_LOADER_TIMEOUT_EN` defined:
  - Outside IDLE, a cycle counter reloads on every accepted byte.
  - When it reaches `TIMEOUT`, the FSM returns to IDLE and queues `{8'h45, cmd, 16'h0001}`.
  - Words already written stay written.
- Not defined: no counter; the FSM waits indefinitely for the next byte.

## Test plan
- Insn load: send `49 00 00 00 00 02 00 13 00 00 00 6F 00 00 00`.
  - `insn_we` pulses twice: addr 0x0 din 0x00000013, then addr 0x4 din 0x0000006F.
  - `tx_din` = 0x4B490002.
- Data load with wrap: send 'D', addr 0xFFFFFFFC, N=2.
  - Writes land at 0xFFFFFFFC then 0x00000000; `data_we` only, never `insn_we`.
- Run: send 52.
  - Ack 0x4B520000; `run` rises `RUN_DELAY`+1 cycles after acceptance.
  - Sending 48 drops `run` next cycle; ack 0x4B480000.
- Arbitration: hold `fifo_valid`=1 with `fifo_dout`=0xDEADBEEF and `tx_ready`=1, then complete a packet.
  - The ack word goes out before the next FIFO word.
  - `fifo_rd_en` count equals the number of 0xDEADBEEF kicks.
- Error, drop and reset:
  - Send 0x7A → ack 0x457A0000.
  - Send two 'R' while `tx_ready`=0 → second `ack_drop` pulse.
  - Assert reset after 3 payload bytes → no write and no ack.
- Timeout (macro on, `TIMEOUT`=50): stop after the address bytes.
  - After 50 idle cycles, ack 0x45490001; the next packet is parsed correctly from IDLE.

Source files
------------

// File: rtl/uart_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : uart_loader_ctrl
// Brief   : UART byte-command boot loader (I/D/R/H) with shared-TX arbiter.
//           Optional mid-packet timeout: UART_LOADER_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module uart_loader_ctrl #(
    parameter int unsigned RUN_DELAY = 100,
    parameter int unsigned TIMEOUT   = 5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_rd,
    input  logic [7:0]  rx_dout,
    output logic [31:0] insn_addr,
    output logic [31:0] insn_din,
    output logic        insn_we,
    output logic [31:0] data_addr,
    output logic [31:0] data_din,
    output logic        data_we,
    output logic        run,
    input  logic        fifo_valid,
    input  logic [31:0] fifo_dout,
    output logic        fifo_rd_en,
    input  logic        tx_ready,
    output logic        tx_wr,
    output logic [31:0] tx_din,
    output logic        ack_drop
);

    localparam logic [7:0] CMD_I   = 8'h49;
    localparam logic [7:0] CMD_D   = 8'h44;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] CMD_H   = 8'h48;
    localparam logic [7:0] ACK_OK  = 8'h4B;
    localparam logic [7:0] ACK_ERR = 8'h45;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ADDR    = 2'd1,
        S_LEN     = 2'd2,
        S_PAYLOAD = 2'd3
    } state_t;

    state_t      state, state_n;
    logic        rx_rd_q;
    logic [1:0]  idx;
    logic [7:0]  cmd;
    logic        is_data;
    logic [31:0] addr_q;
    logic [15:0] len_q;
    logic [15:0] word_cnt;
    logic [23:0] word_buf;
    logic        ack_full;
    logic [31:0] ack_word;
    logic        dly_active;
    logic [31:0] dly_cnt;

    logic        byte_acc;
    logic        wr_fire;
    logic        ack_push;
    logic [31:0] ack_val;
    logic        hdr_acc;
    logic        run_acc;
    logic        halt_acc;
    logic [15:0] len_n;
    logic        last_word;
    logic [31:0] wr_word;
    logic        take_ack;

`ifdef UART_LOADER_TIMEOUT_EN
    logic [31:0] tcnt;
`endif

    assign byte_acc = rx_rd && !rx_rd_q;
    assign wr_word  = {rx_dout, word_buf};
    // Ack slot may only be offered to the transmitter when no kick was issued last cycle.
    assign take_ack = tx_ready && !tx_wr && ack_full;

    always_comb begin
        state_n   = state;
        wr_fire   = 1'b0;
        ack_push  = 1'b0;
        ack_val   = 32'h0;
        hdr_acc   = 1'b0;
        run_acc   = 1'b0;
        halt_acc  = 1'b0;
        len_n     = {rx_dout, len_q[15:8]};
        last_word = (word_cnt == len_q - 16'd1);
        if (byte_acc) begin
            case (state)
                S_IDLE: begin
                    case (rx_dout)
                        CMD_I, CMD_D: begin
                            hdr_acc = 1'b1;
                            state_n = S_ADDR;
                        end
                        CMD_R: begin
                            run_acc  = 1'b1;
                            ack_push = 1'b1;
                            ack_val  = {ACK_OK, CMD_R, 16'h0000};
                        end
                        CMD_H: begin
                            halt_acc = 1'b1;
                            ack_push = 1'b1;
                            ack_val  = {ACK_OK, CMD_H, 16'h0000};
                        end
                        default: begin
                            ack_push = 1'b1;
                            ack_val  = {ACK_ERR, rx_dout, 16'h0000};
                        end
                    endcase
                end
                S_ADDR: begin
                    if (idx == 2'd3) state_n = S_LEN;
                end
                S_LEN: begin
                    if (idx == 2'd1) begin
                        if (len_n == 16'h0000) begin
                            ack_push = 1'b1;
                            ack_val  = {ACK_OK, cmd, 16'h0000};
                            state_n  = S_IDLE;
                        end else begin
                            state_n  = S_PAYLOAD;
                        end
                    end
                end
                default: begin
                    if (idx == 2'd3) begin
                        wr_fire = 1'b1;
                        if (last_word) begin
                            ack_push = 1'b1;
                            ack_val  = {ACK_OK, cmd, len_q};
                            state_n  = S_IDLE;
                        end
                    end
                end
            endcase
        end
`ifdef UART_LOADER_TIMEOUT_EN
        if (!byte_acc && state != S_IDLE && tcnt == TIMEOUT) begin
            ack_push = 1'b1;
            ack_val  = {ACK_ERR, cmd, 16'h0001};
            state_n  = S_IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            rx_rd_q    <= 1'b0;
            idx        <= 2'd0;
            cmd        <= 8'h00;
            is_data    <= 1'b0;
            addr_q     <= 32'h0;
            len_q      <= 16'h0;
            word_cnt   <= 16'h0;
            word_buf   <= 24'h0;
            ack_full   <= 1'b0;
            ack_word   <= 32'h0;
            ack_drop   <= 1'b0;
            dly_active <= 1'b0;
            dly_cnt    <= 32'h0;
            run        <= 1'b0;
            insn_addr  <= 32'h0;
            insn_din   <= 32'h0;
            insn_we    <= 1'b0;
            data_addr  <= 32'h0;
            data_din   <= 32'h0;
            data_we    <= 1'b0;
            tx_wr      <= 1'b0;
            tx_din     <= 32'h0;
            fifo_rd_en <= 1'b0;
        end else begin
            rx_rd_q  <= rx_rd;
            state    <= state_n;
            insn_we  <= 1'b0;
            data_we  <= 1'b0;
            ack_drop <= 1'b0;

            if (state_n != state)
                idx <= 2'd0;
            else if (byte_acc && state != S_IDLE)
                idx <= idx + 2'd1;

            if (hdr_acc) begin
                cmd      <= rx_dout;
                is_data  <= (rx_dout == CMD_D);
                word_cnt <= 16'h0;
            end
            if (byte_acc && state == S_ADDR) addr_q   <= {rx_dout, addr_q[31:8]};
            if (byte_acc && state == S_LEN)  len_q    <= len_n;
            if (byte_acc && state == S_PAYLOAD) word_buf <= {rx_dout, word_buf[23:8]};

            if (wr_fire) begin
                if (is_data) begin
                    data_addr <= addr_q;
                    data_din  <= wr_word;
                    data_we   <= 1'b1;
                end else begin
                    insn_addr <= addr_q;
                    insn_din  <= wr_word;
                    insn_we   <= 1'b1;
                end
                addr_q   <= addr_q + 32'd4;
                word_cnt <= word_cnt + 16'd1;
            end

            if (take_ack) ack_full <= 1'b0;
            if (ack_push) begin
                if (ack_full) begin
                    ack_drop <= 1'b1;
                end else begin
                    ack_full <= 1'b1;
                    ack_word <= ack_val;
                end
            end

            // A load header or halt cancels any pending start, including one expiring now.
            if (hdr_acc || halt_acc) begin
                run        <= 1'b0;
                dly_active <= 1'b0;
            end else if (run_acc) begin
                if (!run) begin
                    dly_active <= 1'b1;
                    dly_cnt    <= RUN_DELAY;
                end
            end else if (dly_active) begin
                dly_cnt <= dly_cnt - 32'd1;
                if (dly_cnt <= 32'd1) begin
                    run        <= 1'b1;
                    dly_active <= 1'b0;
                end
            end

            tx_wr      <= 1'b0;
            fifo_rd_en <= 1'b0;
            if (take_ack) begin
                tx_wr  <= 1'b1;
                tx_din <= ack_word;
            end else if (tx_ready && !tx_wr && fifo_valid) begin
                tx_wr      <= 1'b1;
                tx_din     <= fifo_dout;
                fifo_rd_en <= 1'b1;
            end
        end
    end

`ifdef UART_LOADER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset || state == S_IDLE || byte_acc)
            tcnt <= 32'h0;
        else
            tcnt <= tcnt + 32'd1;
    end
`endif

endmodule
`default_nettype wire
